beat_recorder: RTL and testbench
================================

Name: beat_recorder

Overview:
- Sits between the PS/2 decoder (7-bit ASCII key code, 0 = no key) and the buzzer rate divider.
- Records timed key sequences into one of three slots and plays a slot back by driving its ASCII output to the buzzer stage.
- Outside playback, live keys pass straight through, so the buzzer always follows either the keyboard or a recording.

Parameters:
DEPTH, 64, entries per slot (power of 2)
DUR_W, 16, duration field width in ticks
TICK_DIV, 50000, clock cycles per duration tick (1 ms at 50 MHz)

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  asynchronous active-low reset
ascii_in  in  7  key code from PS/2 decoder, 0 = none; asynchronous to CLOCK_50
rec_btn_n  in  1  record button level, active-low (KEY0)
play_btn_n  in  1  play button level, active-low (KEY1)
slot_sel  in  3  one-hot slot select (SW2..0)
ascii_out  out  7  key code to rate divider
recording  out  1  high while in REC
playing  out  1  high while in PLOAD/PHOLD
full  out  1  one-cycle pulse when a recording stops on slot capacity
slot_valid  out  3  bit i set when slot i length > 0

Behaviour:
- Reset (async, resetn low): all outputs 0, state IDLE, all slot lengths 0, all counters 0. Memory contents are don't-care. Reset mid-record discards the take; reset mid-play stops immediately.
- ascii_in passes through a 2-flop synchroniser giving key_s; 2-cycle latency.
- Buttons are 2-flop synchronised. A press event is a 1-to-0 transition, one cycle wide. There is no debounce; the bench drives clean edges.
- Slot decode: lowest set bit of slot_sel wins. slot_sel == 0 means presses are ignored.
- Memory: 3*DEPTH words of {key[6:0], dur[DUR_W-1:0]}, synchronous write and read.
- ascii_out = playback key in PLOAD/PHOLD, else key_s. It is registered, so there is 1 cycle of latency after key_s or state.
- Tick counter counts 0..TICK_DIV-1. A tick fires on wrap. The counter is cleared on every entry write and on every PLOAD.
- States:
  - IDLE:
    - rec press with valid slot -> REC; latch slot, ptr=0, cur_key=key_s, dur=0.
    - play press with valid slot and len>0 -> PLOAD; ptr=0.
    - play press with len==0 -> stays IDLE.
  - REC:
    - dur increments on each tick.
    - An entry {cur_key,dur} is written at ptr, then ptr++, dur=0, on any of:
      - key_s != cur_key; cur_key then takes key_s.
      - dur reaches all-ones; cur_key is unchanged, the note continues in the next entry.
      - rec press; final entry, then len[slot]=ptr+1, -> IDLE.
    - If a write lands at ptr == DEPTH-1: len=DEPTH, full pulses, -> IDLE.
    - play presses are ignored in REC.
    - slot_sel changes mid-record are ignored; the slot is latched.
  - PLOAD: issue read at ptr. Next cycle, latch key/dur into hold regs -> PHOLD. ascii_out shows the previous key during this cycle (0 for the first entry).
  - PHOLD:
    - Output the held key.
    - Decrement the held dur on each tick.
    - When the held dur == 0: ptr++; -> PLOAD if ptr < len, else -> IDLE.
    - A dur==0 entry therefore occupies 1 PHOLD cycle.
    - A play press aborts -> IDLE.
    - A rec press is ignored.
- Re-recording a slot overwrites it. The new len replaces the old one only when the recording stops.
- Simultaneous rec and play press in IDLE: rec wins.

Optional Feature:
- Macro LOOP_PLAYBACK_EN.
- Defined: on end of slot, PHOLD -> PLOAD with ptr=0, repeating until a play press, which returns to IDLE.
- Undefined: playback ends after the last entry, as above.

Test Plan (TICK_DIV=4, DEPTH=8):
- Reset: hold resetn low mid-play -> ascii_out=0, playing=0, slot_valid=000 immediately and after release.
- Passthrough: ascii_in=0x61 in IDLE -> ascii_out=0x61 after 3 cycles.
- Record/play:
  - Stimulus: slot_sel=001; rec press; key 0x61 for 40 cycles, 0x00 for 20 cycles, rec press.
  - slot_valid=001.
  - Play press -> playing=1; ascii_out=0x61 for about 40 cycles, then 0x00 for about 20 (±TICK_DIV+3); then playing=0, ascii_out follows live.
- Capacity: 9 alternating keys while recording slot 2 -> full pulses once on 8th write; recording=0; playback emits exactly 8 keys.
- Empty/conflict checks:
  - play press on empty slot 1 -> playing stays 0.
  - slot_sel=110 records to slot 1.
  - rec+play in same cycle -> recording=1.
- Abort/loop:
  - play press during PHOLD -> IDLE within 3 cycles.
  - With LOOP_PLAYBACK_EN, 2-entry slot replays the sequence ≥3 times until play press.

Source files
------------

// File: rtl/beat_recorder.sv
// Records timed key sequences into three slots and plays them back to the buzzer stage.
// Optional feature: define LOOP_PLAYBACK_EN to repeat a slot until the play button is pressed.
module beat_recorder #(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned DUR_W    = 16,
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [6:0] ascii_in,
    input  logic       rec_btn_n,
    input  logic       play_btn_n,
    input  logic [2:0] slot_sel,
    output logic [6:0] ascii_out,
    output logic       recording,
    output logic       playing,
    output logic       full,
    output logic [2:0] slot_valid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned EW = 7 + DUR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REC,
        S_PLOAD,
        S_PHOLD
    } state_t;

    state_t               state_q, state_d;
    logic [6:0]           key_m_q, key_s_q;
    logic [2:0]           rec_sync_q, play_sync_q;
    logic                 rec_press, play_press;
    logic                 sel_ok;
    logic [1:0]           sel_slot;
    logic [1:0]           slot_q, slot_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [6:0]           cur_key_q, cur_key_d;
    logic [DUR_W-1:0]     dur_q, dur_d;
    logic [6:0]           hold_key_q, hold_key_d;
    logic [DUR_W-1:0]     hold_dur_q, hold_dur_d;
    logic [2:0][LW-1:0]   len_q, len_d;
    logic [TW-1:0]        tick_q;
    logic                 tick, tick_clr;
    logic [6:0]           out_q;
    logic                 full_q, full_d;
    logic                 we;
    logic [EW-1:0]        mem [3*DEPTH];
    logic [EW-1:0]        rd_q;

    // Sync stage layout: [0] metastable, [1] synchronised, [2] previous synchronised
    assign rec_press  = rec_sync_q[2] & ~rec_sync_q[1];
    assign play_press = play_sync_q[2] & ~play_sync_q[1];
    assign tick       = (tick_q == TW'(TICK_DIV - 1));

    always_comb begin
        sel_ok   = |slot_sel;
        sel_slot = 2'd2;
        if (slot_sel[0]) begin
            sel_slot = 2'd0;
        end else if (slot_sel[1]) begin
            sel_slot = 2'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        ptr_d      = ptr_q;
        cur_key_d  = cur_key_q;
        dur_d      = dur_q;
        hold_key_d = hold_key_q;
        hold_dur_d = hold_dur_q;
        len_d      = len_q;
        full_d     = 1'b0;
        we         = 1'b0;
        tick_clr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rec_press && sel_ok) begin
                    state_d   = S_REC;
                    slot_d    = sel_slot;
                    ptr_d     = '0;
                    cur_key_d = key_s_q;
                    dur_d     = '0;
                end else if (play_press && sel_ok && (len_q[sel_slot] != '0)) begin
                    state_d    = S_PLOAD;
                    slot_d     = sel_slot;
                    ptr_d      = '0;
                    hold_key_d = '0;
                end
            end
            S_REC: begin
                if (tick) begin
                    dur_d = dur_q + DUR_W'(1);
                end
                if ((key_s_q != cur_key_q) || (dur_q == '1) || rec_press) begin
                    we       = 1'b1;
                    tick_clr = 1'b1;
                    dur_d    = '0;
                    if (ptr_q == PW'(DEPTH - 1)) begin
                        len_d[slot_q] = LW'(DEPTH);
                        full_d        = 1'b1;
                        state_d       = S_IDLE;
                    end else if (rec_press) begin
                        len_d[slot_q] = LW'(ptr_q) + LW'(1);
                        state_d       = S_IDLE;
                    end else begin
                        ptr_d     = ptr_q + PW'(1);
                        cur_key_d = key_s_q;
                    end
                end
            end
            // Read address follows ptr_d, so rd_q already holds the entry at ptr here
            S_PLOAD: begin
                tick_clr   = 1'b1;
                hold_key_d = rd_q[EW-1:DUR_W];
                hold_dur_d = rd_q[DUR_W-1:0];
                state_d    = S_PHOLD;
            end
            S_PHOLD: begin
                if (play_press) begin
                    state_d = S_IDLE;
                end else if (hold_dur_q == '0) begin
                    ptr_d = ptr_q + PW'(1);
                    if ((LW'(ptr_q) + LW'(1)) < len_q[slot_q]) begin
                        state_d = S_PLOAD;
                    end else begin
`ifdef LOOP_PLAYBACK_EN
                        ptr_d   = '0;
                        state_d = S_PLOAD;
`else
                        state_d = S_IDLE;
`endif
                    end
                end else if (tick) begin
                    hold_dur_d = hold_dur_q - DUR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            key_m_q     <= '0;
            key_s_q     <= '0;
            rec_sync_q  <= '1;
            play_sync_q <= '1;
            slot_q      <= '0;
            ptr_q       <= '0;
            cur_key_q   <= '0;
            dur_q       <= '0;
            hold_key_q  <= '0;
            hold_dur_q  <= '0;
            len_q       <= '0;
            tick_q      <= '0;
            out_q       <= '0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_m_q     <= ascii_in;
            key_s_q     <= key_m_q;
            rec_sync_q  <= {rec_sync_q[1:0], rec_btn_n};
            play_sync_q <= {play_sync_q[1:0], play_btn_n};
            slot_q      <= slot_d;
            ptr_q       <= ptr_d;
            cur_key_q   <= cur_key_d;
            dur_q       <= dur_d;
            hold_key_q  <= hold_key_d;
            hold_dur_q  <= hold_dur_d;
            len_q       <= len_d;
            tick_q      <= (tick_clr || tick) ? '0 : tick_q + TW'(1);
            out_q       <= ((state_q == S_PLOAD) || (state_q == S_PHOLD)) ? hold_key_q : key_s_q;
            full_q      <= full_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (we) begin
            mem[{slot_q, ptr_q}] <= {cur_key_q, dur_q};
        end
        rd_q <= mem[{slot_d, ptr_d}];
    end

    assign ascii_out  = out_q;
    assign recording  = (state_q == S_REC);
    assign playing    = (state_q == S_PLOAD) || (state_q == S_PHOLD);
    assign full       = full_q;
    assign slot_valid = {len_q[2] != '0, len_q[1] != '0, len_q[0] != '0};

endmodule

// File: tb/tb_beat_recorder.sv
// Directed bench for beat_recorder with DEPTH=8, TICK_DIV=4; expected values are hand-derived.
module tb_beat_recorder;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned DUR_W    = 16;
    localparam int unsigned TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] ascii_in;
    logic       rec_btn_n;
    logic       play_btn_n;
    logic [2:0] slot_sel;
    logic [6:0] ascii_out;
    logic       recording;
    logic       playing;
    logic       full;
    logic [2:0] slot_valid;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    beat_recorder #(
        .DEPTH    (DEPTH),
        .DUR_W    (DUR_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .ascii_in   (ascii_in),
        .rec_btn_n  (rec_btn_n),
        .play_btn_n (play_btn_n),
        .slot_sel   (slot_sel),
        .ascii_out  (ascii_out),
        .recording  (recording),
        .playing    (playing),
        .full       (full),
        .slot_valid (slot_valid)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds the selected buttons low for 3 cycles; the resulting state is visible on return.
    task automatic press(input bit r, input bit p);
        if (r) rec_btn_n = 1'b0;
        if (p) play_btn_n = 1'b0;
        cycles(3);
        rec_btn_n  = 1'b1;
        play_btn_n = 1'b1;
    endtask

    task automatic wait_out(input logic [6:0] key, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (ascii_out == key) seen = 1'b1;
        end
    endtask

    task automatic watch_play(input int budget, output int runs, output int last_key,
                              output int c61, output int c0, output bit started, output bit ended);
        logic [6:0] prev;
        bit         seen61;
        runs = 0; last_key = 0; c61 = 0; c0 = 0;
        started = 1'b0; ended = 1'b0; seen61 = 1'b0;
        prev = ascii_out;
        for (int i = 0; i < budget && !ended; i++) begin
            @(negedge clk);
            if (playing) begin
                started = 1'b1;
                if (ascii_out != prev && ascii_out != 7'h00) begin
                    runs++;
                    last_key = int'(ascii_out);
                end
                if (ascii_out == 7'h61) begin
                    c61++;
                    seen61 = 1'b1;
                end else if (ascii_out == 7'h00 && seen61) begin
                    c0++;
                end
            end else if (started) begin
                ended = 1'b1;
            end
            prev = ascii_out;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int runs, last_key, c61, c0, nfull, cnt;
        bit started, ended, seen;

        resetn = 1'b0; ascii_in = '0; rec_btn_n = 1'b1; play_btn_n = 1'b1; slot_sel = '0;
        cycles(3);
        check("rst_hold_out", int'(ascii_out), 0);
        resetn = 1'b1;
        cycles(2);
        check("rst_out", int'(ascii_out), 0);
        check("rst_playing", int'(playing), 0);
        check("rst_recording", int'(recording), 0);
        check("rst_full", int'(full), 0);
        check("rst_slot_valid", int'(slot_valid), 0);

        // Live passthrough: 2-flop sync plus output register
        ascii_in = 7'h61;
        cycles(2);
        check("pass_lat2", int'(ascii_out), 0);
        cycles(1);
        check("pass_lat3", int'(ascii_out), 'h61);
        ascii_in = '0;
        cycles(4);

        // Record slot 0: 0x61 for 40 cycles, silence for 20
        slot_sel = 3'b001;
        press(1'b1, 1'b0);
        check("rec0_start", int'(recording), 1);
        ascii_in = 7'h61;
        cycles(40);
        ascii_in = 7'h00;
        cycles(20);
        press(1'b1, 1'b0);
        check("rec0_stop", int'(recording), 0);
        check("rec0_valid", int'(slot_valid), 'b001);
        cycles(3);

        press(1'b0, 1'b1);
`ifndef LOOP_PLAYBACK_EN
        watch_play(200, runs, last_key, c61, c0, started, ended);
        $display("info: key 0x61 held %0d cycles, silence %0d cycles", c61, c0);
        check("play0_start", int'(started), 1);
        check("play0_end", int'(ended), 1);
        check("play0_runs", runs, 1);
        check("play0_len61", int'(c61 >= 33 && c61 <= 47), 1);
        check("play0_len00", int'(c0 >= 13 && c0 <= 27), 1);
`else
        watch_play(250, runs, last_key, c61, c0, started, ended);
        check("loop0_start", int'(started), 1);
        check("loop0_repeats", int'(runs >= 3), 1);
        wait_out(7'h61, 100, seen);
        check("loop0_seen", int'(seen), 1);
        press(1'b0, 1'b1);
        check("loop0_stop", int'(playing), 0);
`endif
        ascii_in = 7'h62;
        cycles(3);
        check("live_after_play", int'(ascii_out), 'h62);
        ascii_in = 7'h00;
        cycles(4);

        // Abort during a long held note
        press(1'b0, 1'b1);
        wait_out(7'h61, 60, seen);
        check("abort_reach_note", int'(seen), 1);
        cycles(5);
        play_btn_n = 1'b0;
        cycles(2);
        check("abort_still_play", int'(playing), 1);
        cycles(1);
        check("abort_idle", int'(playing), 0);
        play_btn_n = 1'b1;
        cycles(2);
        check("abort_out_live", int'(ascii_out), 0);
        cycles(3);

        // Capacity: keys 0x41..0x49 into slot 2, eighth write fills it
        slot_sel = 3'b100;
        ascii_in = 7'h41;
        cycles(4);
        press(1'b1, 1'b0);
        check("cap_start", int'(recording), 1);
        nfull = 0;
        for (int k = 1; k <= 8; k++) begin
            ascii_in = 7'h41 + 7'(k);
            repeat (6) begin
                @(negedge clk);
                if (full) nfull++;
            end
        end
        repeat (4) begin
            @(negedge clk);
            if (full) nfull++;
        end
        check("cap_full_pulses", nfull, 1);
        check("cap_recording", int'(recording), 0);
        check("cap_valid", int'(slot_valid), 'b101);
        ascii_in = 7'h00;
        cycles(4);
        press(1'b0, 1'b1);
`ifndef LOOP_PLAYBACK_EN
        watch_play(200, runs, last_key, c61, c0, started, ended);
        check("cap_play_end", int'(ended), 1);
        check("cap_play_keys", runs, 8);
        check("cap_play_last", last_key, 'h48);
`else
        wait_out(7'h44, 100, seen);
        check("cap_loop_seen", int'(seen), 1);
        press(1'b0, 1'b1);
        check("cap_loop_stop", int'(playing), 0);
`endif
        cycles(3);

        // Play on empty slot 1 is ignored
        slot_sel = 3'b010;
        cycles(2);
        play_btn_n = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (playing) cnt++;
        end
        play_btn_n = 1'b1;
        cycles(3);
        check("empty_play", cnt, 0);

        // slot_sel=110 selects slot 1 (lowest set bit)
        ascii_in = 7'h55;
        slot_sel = 3'b110;
        cycles(4);
        press(1'b1, 1'b0);
        check("sel110_rec", int'(recording), 1);
        cycles(12);
        press(1'b1, 1'b0);
        check("sel110_valid", int'(slot_valid), 'b111);
        ascii_in = 7'h00;
        cycles(4);

        // Simultaneous rec and play press: rec wins
        slot_sel = 3'b001;
        press(1'b1, 1'b1);
        check("both_rec", int'(recording), 1);
        check("both_play", int'(playing), 0);
        cycles(5);
        press(1'b1, 1'b0);
        check("both_rec_stop", int'(recording), 0);
        cycles(3);

        // Asynchronous reset in the middle of playback
        slot_sel = 3'b100;
        press(1'b0, 1'b1);
        cycles(5);
        check("rstmid_pre_play", int'(playing), 1);
        #2 resetn = 1'b0;
        #1;
        check("rstmid_out", int'(ascii_out), 0);
        check("rstmid_playing", int'(playing), 0);
        check("rstmid_valid", int'(slot_valid), 0);
        @(negedge clk);
        resetn = 1'b1;
        cycles(2);
        check("rstrel_out", int'(ascii_out), 0);
        check("rstrel_playing", int'(playing), 0);
        check("rstrel_valid", int'(slot_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
